// File: rtl/control_pkg.sv
// Shared constants and types for the multi-cycle control unit: opcodes, ALU codes,
// state and instruction-class enumerations, and the Moore control bundle.
package control_pkg;

    localparam logic [5:0] OP_ALU_R = 6'b100000;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_EXEC_I  = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_ALU  = 4'd7,
        S_WB_MEM  = 4'd8,
        S_BRANCH  = 4'd9
    } state_e;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_ALU_R   = 3'd1,
        CLS_ALU_I   = 3'd2,
        CLS_LW      = 3'd3,
        CLS_SW      = 3'd4,
        CLS_BEQ     = 3'd5,
        CLS_BNE     = 3'd6
    } instr_class_e;

    typedef struct packed {
        logic       ir_lden;
        logic       pc_lden;
        logic       rf_wren;
        logic       rf_wrdata_sel;
        logic       rf_b_sel;
        logic       alu_bin_sel;
        logic       mem_wren;
        logic       instr_done;
        logic       branch;
        logic       branch_ne;
        logic [3:0] alu_func;
    } ctrl_t;

    // Control bundle for a state; branch PC_sel is resolved later from the live zero flag.
    function automatic ctrl_t moore_ctrl(state_e s, instr_class_e c, logic [3:0] f);
        ctrl_t o;
        o = '0;
        if (s != S_FETCH && s != S_DECODE) o.alu_func = f;
        case (s)
            S_FETCH:   o.ir_lden = 1'b1;
            S_EXEC_I,
            S_MEM_ADR: o.alu_bin_sel = 1'b1;
            S_MEM_WR: begin
                o.mem_wren   = 1'b1;
                o.pc_lden    = 1'b1;
                o.rf_b_sel   = 1'b1;
                o.instr_done = 1'b1;
            end
            S_WB_ALU: begin
                o.rf_wren    = 1'b1;
                o.pc_lden    = 1'b1;
                o.instr_done = 1'b1;
            end
            S_WB_MEM: begin
                o.rf_wren       = 1'b1;
                o.rf_wrdata_sel = 1'b1;
                o.pc_lden       = 1'b1;
                o.instr_done    = 1'b1;
            end
            S_BRANCH: begin
                o.rf_b_sel   = 1'b1;
                o.pc_lden    = 1'b1;
                o.instr_done = 1'b1;
                o.branch     = 1'b1;
                o.branch_ne  = (c == CLS_BNE);
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/control_if.sv
// Control-unit boundary: instruction/flag inputs from the datapath and the control
// bundle back to it, plus the FSM state for observation.
interface control_if;
    import control_pkg::*;

    logic [31:0] Instr;
    logic        ALU_zero;
    logic        IR_LdEn;
    logic        PC_sel;
    logic        PC_LdEn;
    logic        RF_WrEn;
    logic        RF_WrData_sel;
    logic        RF_B_sel;
    logic        ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        MEM_WrEn;
    logic        Instr_done;
    state_e      dbg_state;

    modport master (
        input  Instr, ALU_zero,
        output IR_LdEn, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
               ALU_Bin_sel, ALU_func, MEM_WrEn, Instr_done, dbg_state
    );

    modport slave (
        output Instr, ALU_zero,
        input  IR_LdEn, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
               ALU_Bin_sel, ALU_func, MEM_WrEn, Instr_done, dbg_state
    );

endinterface

// File: rtl/control_decode.sv
// Combinational opcode -> instruction class and ALU operation map.
module control_decode
    import control_pkg::*;
(
    input  logic [5:0]   opcode_i,
    input  logic [3:0]   func_i,
    output instr_class_e class_o,
    output logic [3:0]   alu_func_o
);

    always_comb begin
        class_o    = CLS_ILLEGAL;
        alu_func_o = ALU_ADD;
        case (opcode_i)
            OP_ALU_R: begin class_o = CLS_ALU_R; alu_func_o = func_i;  end
            OP_ADDI:  begin class_o = CLS_ALU_I; alu_func_o = ALU_ADD; end
            OP_ANDI:  begin class_o = CLS_ALU_I; alu_func_o = ALU_AND; end
            OP_ORI:   begin class_o = CLS_ALU_I; alu_func_o = ALU_OR;  end
            OP_LW:    begin class_o = CLS_LW;    alu_func_o = ALU_ADD; end
            OP_SW:    begin class_o = CLS_SW;    alu_func_o = ALU_ADD; end
            OP_BEQ:   begin class_o = CLS_BEQ;   alu_func_o = ALU_SUB; end
            OP_BNE:   begin class_o = CLS_BNE;   alu_func_o = ALU_SUB; end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back and drives
// the datapath control bundle from the state and the opcode captured in DECODE.
module control_fsm
    import control_pkg::*;
(
    input  logic      Clk,
    input  logic      Reset,
    control_if.master ctl
);

    state_e       state_q, state_d;
    logic [5:0]   opcode_q, opcode_d;
    logic [3:0]   func_q, func_d;
    ctrl_t        ctrl_q;
    instr_class_e cls;
    logic [3:0]   alu_func;
    logic         decode_skip;
    logic         unused_instr_bits;

    // DECODE sees the live IR and captures it; every later state uses the captured copy.
    assign opcode_d = (state_q == S_DECODE) ? ctl.Instr[31:26] : opcode_q;
    assign func_d   = (state_q == S_DECODE) ? ctl.Instr[3:0]   : func_q;
    assign unused_instr_bits = ^ctl.Instr[25:4];

    control_decode u_decode (
        .opcode_i   (opcode_d),
        .func_i     (func_d),
        .class_o    (cls),
        .alu_func_o (alu_func)
    );

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CLS_ALU_R:      state_d = S_EXEC_R;
                    CLS_ALU_I:      state_d = S_EXEC_I;
                    CLS_LW, CLS_SW: state_d = S_MEM_ADR;
                    CLS_BEQ,
                    CLS_BNE:        state_d = S_BRANCH;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADR: state_d = (cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  state_d = S_WB_MEM;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            func_q   <= '0;
            ctrl_q   <= moore_ctrl(S_FETCH, CLS_ILLEGAL, 4'b0000);
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            func_q   <= func_d;
            ctrl_q   <= moore_ctrl(state_d, cls, alu_func);
        end
    end

    // An illegal opcode is only known once the IR is valid in DECODE, so its skip is decoded live.
    assign decode_skip = (state_q == S_DECODE) && (cls == CLS_ILLEGAL);

    assign ctl.IR_LdEn       = ~Reset & ctrl_q.ir_lden;
    assign ctl.PC_LdEn       = ~Reset & (ctrl_q.pc_lden | decode_skip);
    assign ctl.Instr_done    = ~Reset & (ctrl_q.instr_done | decode_skip);
    assign ctl.PC_sel        = ~Reset & ctrl_q.branch & (ctl.ALU_zero ^ ctrl_q.branch_ne);
    assign ctl.RF_WrEn       = ~Reset & ctrl_q.rf_wren;
    assign ctl.RF_WrData_sel = ~Reset & ctrl_q.rf_wrdata_sel;
    assign ctl.RF_B_sel      = ~Reset & ctrl_q.rf_b_sel;
    assign ctl.ALU_Bin_sel   = ~Reset & ctrl_q.alu_bin_sel;
    assign ctl.MEM_WrEn      = ~Reset & ctrl_q.mem_wren;
    assign ctl.ALU_func      = {4{~Reset}} & ctrl_q.alu_func;
    assign ctl.dbg_state     = state_q;

endmodule
